// File: rtl/cpu_pkg.sv
// Shared types and constants for the BCD display sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active-low gfedcba, all segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba codes for digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Double-dabble correction: a nibble of 5 or more would carry wrongly after the shift.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD digit to active-low seven-segment encoder with blanking.
module seg7_enc
  import cpu_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Non-decimal nibbles and blanked digits both show nothing.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/y_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving three seven-segment digits.
// Outputs only change on the cycle after DONE, so the displays never show partial results.
module y_bcd_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = 9,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_ten,
  output logic [3:0]       bcd_one,
  output logic [6:0]       seg_hund,
  output logic [6:0]       seg_ten,
  output logic [6:0]       seg_one
);

  // {BCD hundreds, tens, ones, binary operand}
  localparam int unsigned SW = 12 + WIDTH;

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d, sr_adj;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      hund_q, ten_q, one_q;
  logic            done_q;
  logic            blank_hund, blank_ten;

  // Next-state, shift register and iteration counter.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sr_adj  = sr_q;
    sr_adj[SW-1 -: 4] = dabble(sr_q[SW-1 -: 4]);
    sr_adj[SW-5 -: 4] = dabble(sr_q[SW-5 -: 4]);
    sr_adj[SW-9 -: 4] = dabble(sr_q[SW-9 -: 4]);
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {12'd0, y_in};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = {sr_adj[SW-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; the digit latch and done pulse follow the DONE state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hund_q  <= '0;
      ten_q   <= '0;
      one_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == DONE);
      if (state_q == DONE) begin
        hund_q <= sr_q[SW-1 -: 4];
        ten_q  <= sr_q[SW-5 -: 4];
        one_q  <= sr_q[SW-9 -: 4];
      end
    end
  end

  // Leading-zero blanking looks only at the latched digits.
  always_comb begin
    blank_hund = BLANK_LZ && (hund_q == 4'd0);
    blank_ten  = BLANK_LZ && (hund_q == 4'd0) && (ten_q == 4'd0);
  end

  assign busy     = (state_q == CONV) || (state_q == DONE);
  assign done     = done_q;
  assign bcd_hund = hund_q;
  assign bcd_ten  = ten_q;
  assign bcd_one  = one_q;

  seg7_enc u_enc_hund (
    .digit (hund_q),
    .blank (blank_hund),
    .seg   (seg_hund)
  );

  seg7_enc u_enc_ten (
    .digit (ten_q),
    .blank (blank_ten),
    .seg   (seg_ten)
  );

  seg7_enc u_enc_one (
    .digit (one_q),
    .blank (1'b0),
    .seg   (seg_one)
  );

endmodule

// File: tb/tb_y_bcd_seq.sv
// Bench for y_bcd_seq: directed scenarios plus random traffic against a transaction-level model.
module tb_y_bcd_seq;

  localparam int unsigned W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] y_in = '0;

  logic       busy0, done0, busy1, done1;
  logic [3:0] h0, t0, o0, h1, t1, o1;
  logic [6:0] sh0, st0, so0, sh1, st1, so1;

  y_bcd_seq #(.WIDTH(W), .BLANK_LZ(1'b0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y_in     (y_in),
    .busy     (busy0),
    .done     (done0),
    .bcd_hund (h0),
    .bcd_ten  (t0),
    .bcd_one  (o0),
    .seg_hund (sh0),
    .seg_ten  (st0),
    .seg_one  (so0)
  );

  y_bcd_seq #(.WIDTH(W), .BLANK_LZ(1'b1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y_in     (y_in),
    .busy     (busy1),
    .done     (done1),
    .bcd_hund (h1),
    .bcd_ten  (t1),
    .bcd_one  (o1),
    .seg_hund (sh1),
    .seg_ten  (st1),
    .seg_one  (so1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a request takes W+1 edges after acceptance to show up on the outputs.
  int m_left = 0;
  int m_cap  = 0;
  int m_val  = 0;
  bit m_done = 1'b0;

  localparam logic [6:0] TB_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] exp_seg(input int d, input bit blank);
    if (blank || d > 9) return 7'b1111111;
    return TB_SEG[d];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_left = 0;
      m_val  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_cap  = int'(y_in);
          m_left = W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_val  = m_cap;
        end
      end
    end
  endtask

  task automatic compare_all();
    int  eh, et, eo;
    bit  bh, bt;
    eh = m_val / 100;
    et = (m_val / 10) % 10;
    eo = m_val % 10;
    bh = (eh == 0);
    bt = (eh == 0) && (et == 0);
    check_eq("busy0", 32'(busy0), 32'(m_left != 0));
    check_eq("done0", 32'(done0), 32'(m_done));
    check_eq("hund0", 32'(h0), 32'(eh));
    check_eq("ten0", 32'(t0), 32'(et));
    check_eq("one0", 32'(o0), 32'(eo));
    check_eq("seg_hund0", 32'(sh0), 32'(exp_seg(eh, 1'b0)));
    check_eq("seg_ten0", 32'(st0), 32'(exp_seg(et, 1'b0)));
    check_eq("seg_one0", 32'(so0), 32'(exp_seg(eo, 1'b0)));
    check_eq("busy1", 32'(busy1), 32'(m_left != 0));
    check_eq("done1", 32'(done1), 32'(m_done));
    check_eq("hund1", 32'(h1), 32'(eh));
    check_eq("ten1", 32'(t1), 32'(et));
    check_eq("one1", 32'(o1), 32'(eo));
    check_eq("seg_hund1", 32'(sh1), 32'(exp_seg(eh, bh)));
    check_eq("seg_ten1", 32'(st1), 32'(exp_seg(et, bt)));
    check_eq("seg_one1", 32'(so1), 32'(exp_seg(eo, 1'b0)));
  endtask

  // Inputs are driven just after the falling edge; outputs are sampled on the next one.
  task automatic step(input bit r, input bit s, input int y);
    rst   = r;
    start = s;
    y_in  = W'(y);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_one(input int y, input int idle_cycles);
    step(1'b0, 1'b1, y);
    for (int i = 0; i < idle_cycles; i++) step(1'b0, 1'b0, int'($urandom_range(0, 511)));
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    run_one(255, 12);
    run_one(511, 12);
    run_one(0, 12);

    // Second start mid-conversion must be ignored.
    step(1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b1, 37);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 37);

    // Reset aborts a conversion in flight.
    step(1'b0, 1'b1, 123);
    step(1'b0, 1'b0, 123);
    step(1'b0, 1'b0, 123);
    step(1'b1, 1'b0, 123);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 123);
    run_one(45, 12);

    // Leading-zero blanking cases for the BLANK_LZ instance.
    run_one(7, 12);
    run_one(305, 12);
    run_one(60, 12);

    // Reset and start together: reset wins.
    step(1'b1, 1'b1, 99);
    step(1'b0, 1'b0, 99);

    // Held start: back-to-back conversions.
    for (int i = 0; i < 35; i++) step(1'b0, 1'b1, int'($urandom_range(0, 511)));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 511)));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
